// File: rtl/seg_scan_hex.sv
// Time-multiplexed hex driver for a common-anode 7-segment bank, with a double-buffered value and dead time.
// Define SEG_SCAN_LZB_EN to add the lzb_i input (leading-zero blanking).
module seg_scan_hex #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  upd_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_mask_i,
  input  logic [DIGITS-1:0]     blank_mask_i,
`ifdef SEG_SCAN_LZB_EN
  input  logic                  lzb_i,
`endif
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_done_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } buf_t;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  buf_t              disp_q, disp_d, pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fd_q, fd_d;

  logic              tick, last, bound, dark;
  logic [3:0]        nib;
  logic [DIGITS-1:0] lzb_blank, blank_eff;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

`ifdef SEG_SCAN_LZB_EN
  logic run;
  // Blank from the top digit down while nibbles are zero; a set dp or digit 0 ends the run.
  always_comb begin
    lzb_blank = '0;
    run       = lzb_i;
    for (int i = DIGITS-1; i >= 1; i--) begin
      if (run && disp_q.val[4*i +: 4] == 4'h0 && !disp_q.dp[i]) lzb_blank[i] = 1'b1;
      else run = 1'b0;
    end
  end
`else
  assign lzb_blank = '0;
`endif

  assign tick      = (cnt_q == CW'(SCAN_DIV-1));
  assign last      = (idx_q == IW'(DIGITS-1));
  assign bound     = en_i && tick && last;
  assign blank_eff = disp_q.blank | lzb_blank;
  assign nib       = disp_q.val[{idx_q, 2'b00} +: 4];
  assign dark      = !en_i || (int'(cnt_q) < DEAD_CYC) || blank_eff[idx_q];

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    fd_d       = bound;
    seg_d      = 8'hFF;
    an_d       = '1;

    if (!en_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = last ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A strobe on the boundary still promotes the old pending data; the new data waits a frame.
    if (bound && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (upd_i) begin
      pend_d     = '{val: value_i, dp: dp_mask_i, blank: blank_mask_i};
      pend_vld_d = 1'b1;
    end

    if (!dark) begin
      seg_d       = {hex7(nib), ~disp_q.dp[idx_q]};
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= 8'hFF;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_scan_hex.sv
// Directed bench for seg_scan_hex at DIGITS=4, SCAN_DIV=4, DEAD_CYC=1 (16-cycle frames).
module tb_seg_scan_hex;

  logic        clk = 1'b0;
  logic        rst_n, en, upd;
  logic [15:0] value;
  logic [3:0]  dp_mask, blank_mask;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
`ifdef SEG_SCAN_LZB_EN
  logic        lzb;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  int          s_off [2];
  logic [15:0] s_val [2];
  logic [3:0]  s_dp  [2];
  logic [3:0]  s_bl  [2];

  seg_scan_hex #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .upd_i        (upd),
    .value_i      (value),
    .dp_mask_i    (dp_mask),
    .blank_mask_i (blank_mask),
`ifdef SEG_SCAN_LZB_EN
    .lzb_i        (lzb),
`endif
    .seg_o        (seg),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched(input int j, input int off, input logic [15:0] v,
                       input logic [3:0] dp, input logic [3:0] bl);
    s_off[j] = off; s_val[j] = v; s_dp[j] = dp; s_bl[j] = bl;
  endtask

  // One 16-cycle frame starting at digit 0; exp = {d3,d2,d1,d0} segment bytes, FF = digit dark.
  task automatic frame(input string tag, input logic [31:0] exp);
    logic [7:0]  s;
    logic [12:0] e;
    int d;
    for (int i = 0; i < 16; i++) begin
      tick();
      upd = 1'b0;
      d = i / 4;
      s = exp[d*8 +: 8];
      if (i % 4 == 0 || s == 8'hFF) e = {i == 15, 4'hF, 8'hFF};
      else                          e = {i == 15, 4'hF & ~(4'b0001 << d), s};
      chk($sformatf("%s[%0d]", tag, i), {19'b0, frame_done, an, seg}, {19'b0, e});
      for (int j = 0; j < 2; j++)
        if (s_off[j] == i) begin
          value = s_val[j]; dp_mask = s_dp[j]; blank_mask = s_bl[j];
          upd = 1'b1; s_off[j] = -1;
        end
    end
    upd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; upd = 1'b0;
    value = '0; dp_mask = '0; blank_mask = '0;
`ifdef SEG_SCAN_LZB_EN
    lzb = 1'b0;
`endif
    s_off[0] = -1; s_off[1] = -1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", {frame_done, an, seg}, {1'b0, 4'hF, 8'hFF});
    end
    rst_n = 1'b1;

    sched(0, 5, 16'h3A0F, 4'b0000, 4'b0000);
    frame("boot_zero", 32'h03030303);
    sched(0, 4, 16'h1111, 4'b0000, 4'b0000);
    frame("decode", 32'h0D110371);
    sched(0, 3, 16'h8888, 4'b0001, 4'b0100);
    sched(1, 14, 16'hC0DE, 4'b0000, 4'b0000);
    frame("tearfree", 32'h9F9F9F9F);
    frame("blank_dp", 32'h01FF0100);
    frame("collide_b", 32'h63038561);

    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      upd = 1'b0;
      chk("en_low", {frame_done, an, seg}, {1'b0, 4'hF, 8'hFF});
      if (i == 1) begin
        value = 16'h1111; dp_mask = '0; blank_mask = '0; upd = 1'b1;
      end
    end
    en = 1'b1;
    frame("en_restart", 32'h63038561);
    frame("en_upd", 32'h9F9F9F9F);

    for (int i = 0; i < 6; i++) begin
      tick();
      upd = (i == 2);
      if (i == 2) value = 16'h2222;
    end
    upd   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_reset", {frame_done, an, seg}, {1'b0, 4'hF, 8'hFF});
    end
    rst_n = 1'b1;
    frame("post_reset0", 32'h03030303);
    frame("post_reset1", 32'h03030303);

`ifdef SEG_SCAN_LZB_EN
    lzb = 1'b1;
    sched(0, 4, 16'h0050, 4'b0000, 4'b0000);
    frame("lzb_zero_a", 32'hFFFFFF03);
    sched(0, 4, 16'h0000, 4'b0000, 4'b0000);
    frame("lzb_0050", 32'hFFFF4903);
    frame("lzb_zero_b", 32'hFFFFFF03);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
